// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the 2:1 memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_arb_2to1_if.sv
// Request/response and memory-side signals of the 2:1 arbiter.
// The slave modport is the arbiter; the master modport drives requesters and memory.
interface mem_arb_2to1_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req0_val;
  logic              req0_rdy;
  logic              req0_type;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              resp0_val;
  logic [DATA_W-1:0] resp0_data;

  logic              req1_val;
  logic              req1_rdy;
  logic              req1_type;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              resp1_val;
  logic [DATA_W-1:0] resp1_data;

  logic              memreq_val;
  logic              memreq_type;
  logic [ADDR_W-1:0] memreq_addr;
  logic [DATA_W-1:0] memreq_wdata;
  logic              memresp_val;
  logic [DATA_W-1:0] memresp_data;

  modport slave (
    input  req0_val, req0_type, req0_addr, req0_wdata,
    output req0_rdy, resp0_val, resp0_data,
    input  req1_val, req1_type, req1_addr, req1_wdata,
    output req1_rdy, resp1_val, resp1_data,
    output memreq_val, memreq_type, memreq_addr, memreq_wdata,
    input  memresp_val, memresp_data
  );

  modport master (
    output req0_val, req0_type, req0_addr, req0_wdata,
    input  req0_rdy, resp0_val, resp0_data,
    output req1_val, req1_type, req1_addr, req1_wdata,
    input  req1_rdy, resp1_val, resp1_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata,
    output memresp_val, memresp_data
  );

endinterface

// File: rtl/mem_arb_2to1_grant.sv
// Combinational grant selection. Round-robin by default; define MEM_ARB_FIXED_PRIO_EN
// for fixed priority where the data port always wins contention.
module mem_arb_2to1_grant
  import mem_arb_pkg::*;
(
  input  logic val0_i,
  input  logic val1_i,
  input  logic last_grant_i,
  output logic grant_val_o,
  output logic grant_idx_o
);

  assign grant_val_o = val0_i | val1_i;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  assign grant_idx_o = val1_i ? PORT_DATA : PORT_FETCH;
`else
  always_comb begin
    grant_idx_o = PORT_FETCH;
    if (val0_i && val1_i) begin
      // Contention: hand the grant to whichever port did not win last time.
      grant_idx_o = ~last_grant_i;
    end else if (val1_i) begin
      grant_idx_o = PORT_DATA;
    end
  end
`endif

endmodule

// File: rtl/mem_arb_2to1.sv
// Shares one single-ported memory between fetch (port 0) and data (port 1) requesters,
// one outstanding transaction at a time. Optional macro: MEM_ARB_FIXED_PRIO_EN.
module mem_arb_2to1
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arb_2to1_if.slave  bus_io
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;

  logic grant_val;
  logic grant_idx;

  logic              mux_type;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  logic req0_rdy, req1_rdy;
  logic resp0_val, resp1_val;
  logic memreq_val;

  mem_arb_2to1_grant u_grant (
    .val0_i       (bus_io.req0_val),
    .val1_i       (bus_io.req1_val),
    .last_grant_i (last_grant_q),
    .grant_val_o  (grant_val),
    .grant_idx_o  (grant_idx)
  );

  assign mux_type  = (grant_idx == PORT_DATA) ? bus_io.req1_type  : bus_io.req0_type;
  assign mux_addr  = (grant_idx == PORT_DATA) ? bus_io.req1_addr  : bus_io.req0_addr;
  assign mux_wdata = (grant_idx == PORT_DATA) ? bus_io.req1_wdata : bus_io.req0_wdata;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req0_rdy     = 1'b0;
    req1_rdy     = 1'b0;
    resp0_val    = 1'b0;
    resp1_val    = 1'b0;
    memreq_val   = 1'b0;

    // Outputs stay quiet during the reset cycle regardless of the current state.
    if (!rst) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (grant_val) begin
            memreq_val   = 1'b1;
            req0_rdy     = (grant_idx == PORT_FETCH);
            req1_rdy     = (grant_idx == PORT_DATA);
            owner_d      = grant_idx;
            last_grant_d = grant_idx;
            state_d      = ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (bus_io.memresp_val) begin
            resp0_val = (owner_q == PORT_FETCH);
            resp1_val = (owner_q == PORT_DATA);
            state_d   = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= PORT_FETCH;
      last_grant_q <= PORT_DATA;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus_io.req0_rdy     = req0_rdy;
  assign bus_io.req1_rdy     = req1_rdy;
  assign bus_io.resp0_val    = resp0_val;
  assign bus_io.resp1_val    = resp1_val;
  assign bus_io.resp0_data   = bus_io.memresp_data;
  assign bus_io.resp1_data   = bus_io.memresp_data;
  assign bus_io.memreq_val   = memreq_val;
  assign bus_io.memreq_type  = mux_type;
  assign bus_io.memreq_addr  = mux_addr;
  assign bus_io.memreq_wdata = mux_wdata;

endmodule

// File: doc/mem_arb_2to1.md
Name: mem_arb_2to1

Overview:
- Shares one single-ported data/instruction memory between two requesters: port 0 is instruction fetch, port 1 is data load/store.
- Sits between the multicycle TinyRV1 processor and the memory, replacing separate imem/dmem paths.
- Uses val/rdy request handshakes, allows at most one outstanding memory transaction, and routes each response back to the port that issued it.
- Arbitration is round-robin.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, write-data and read-data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_val  in  1  port 0 (fetch) request valid
- req0_rdy  out  1  port 0 request accepted this cycle
- req0_type  in  1  0=read, 1=write
- req0_addr  in  ADDR_W  port 0 address
- req0_wdata  in  DATA_W  port 0 write data
- resp0_val  out  1  port 0 response valid (one-cycle pulse)
- resp0_data  out  DATA_W  port 0 response data
- req1_val, req1_rdy, req1_type, req1_addr, req1_wdata  as above, for port 1 (data)
- resp1_val, resp1_data  as above, for port 1
- memreq_val  out  1  memory request valid
- memreq_type  out  1  forwarded request type
- memreq_addr  out  ADDR_W  forwarded address
- memreq_wdata  out  DATA_W  forwarded write data
- memresp_val  in  1  memory response valid
- memresp_data  in  DATA_W  memory response data

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high.
- Memory always accepts memreq_val. Memory returns exactly one memresp_val per request, at least 1 cycle later, with any latency.
- State machine has two states:
  - IDLE: no transaction outstanding.
  - BUSY: waiting for memresp_val.
- IDLE behaviour:
  - If any reqN_val is high, grant exactly one port and assert that port's reqN_rdy in the same cycle (rdy is combinational on val).
  - In that cycle, memreq_val=1 and memreq_type/addr/wdata are muxed from the winner.
  - Latch the owner index and go to BUSY.
  - If no request is valid: memreq_val=0, both rdy=0, stay in IDLE.
- BUSY behaviour:
  - req0_rdy=req1_rdy=0 and memreq_val=0.
  - On memresp_val: assert resp<owner>_val=1 and resp<owner>_data=memresp_data for that one cycle, then go to IDLE.
  - The next grant happens no earlier than the following cycle. Back-to-back throughput is therefore one transaction per (latency+1) cycles.
- Round-robin arbitration:
  - A 1-bit last_grant register records the most recently granted port.
  - On contention (both val high in IDLE), grant the port not equal to last_grant.
  - A single requester wins regardless of last_grant.
  - last_grant updates on every grant.
- Writes also receive a response pulse. resp data for a write is whatever memresp_data carries; requesters ignore it.
- Response data path:
  - resp0_data and resp1_data are both driven with memresp_data at all times.
  - Only the owner's val is asserted.
  - The non-owner's resp val is always 0.
- Reset values:
  - State=IDLE, last_grant=1 (port 0 wins the first contention).
  - All rdy, resp val and memreq_val outputs are 0 during the reset cycle.
- Boundary conditions:
  - memresp_val in IDLE is spurious: ignore it, assert no resp val, no state change.
  - rst asserted in BUSY: return to IDLE and drop the pending owner. A later memresp_val for the dropped transaction is then ignored as spurious.
  - A requester lowering val in the same cycle it would be granted is never granted (grant depends on current-cycle val only).
  - Request fields are sampled only in the grant cycle. The memory is responsible for holding what it needs.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority, with port 1 (data) always winning contention. The last_grant register is not built.
- Undefined: round-robin as specified above.
- Single-requester and handshake behaviour are identical in both builds.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_BUSY}
  - port index constants PORT_FETCH=0, PORT_DATA=1
  - request type constants MEM_READ=0, MEM_WRITE=1
- One combinational sub-module, mem_arb_2to1_grant: inputs val0, val1, last_grant; outputs grant_val, grant_idx. The optional-feature switch lives in this sub-module.
- FSM, owner register and muxing stay in the top module.

Test Plan:
- Single fetch: req0 read addr 0x100, memory latency 2, data 0xdeadbeef.
  - Required: req0_rdy=1 in cycle 0; memreq_addr=0x100.
  - resp0_val=1 with 0xdeadbeef in cycle 2; resp1_val stays 0.
- Contention after reset: req0 read 0x200 and req1 write 0x300/0x12345678 both held.
  - Required: port 0 granted first; port 1 granted the cycle after resp0.
  - memreq_type=1, wdata=0x12345678. Repeat, and grants alternate 0,1,0,1.
- Backpressure: req1 asserted while BUSY on port 0, latency 3.
  - Required: req1_rdy=0 for all BUSY cycles; granted the cycle after resp0_val.
- Spurious response: memresp_val=1 with 0xcafe in IDLE with no requests.
  - Required: resp0_val=resp1_val=0; next req0 read still granted normally.
- Reset mid-transaction: grant port 1, assert rst in BUSY, then memresp_val arrives.
  - Required: no resp1_val; after reset, contention grants port 0.
- MEM_ARB_FIXED_PRIO_EN build: both ports continuously valid for 4 transactions.
  - Required: all 4 grants go to port 1; port 0 is granted only when req1_val drops.
